// File: rtl/fmadd_round_pipe.sv
// fmadd_round_pipe: two-stage valid/ready rounding stage for the FMADD add path.
// Takes a normalised sum (hidden bit, pre-overflow exponent bit, G/R/S), resolves
// the dynamic rounding mode, rounds, and saturates or flushes the result.
// It produces IEEE-754 fields and RISC-V fflags, and keeps a sticky flag accumulator.
// S1 registers the rounded significand and the incremented exponent.
// S2 registers the overflow/tiny resolution and the final outputs.
`timescale 1ns/1ps
module fmadd_round_pipe #(
   parameter int std   = 31,
   parameter int man   = 22,
   parameter int exp   = 7,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [man+1:0]     in_mantissa,
   input  logic [exp+1:0]     in_exponent,
   input  logic               in_sign,
   input  logic               in_guard,
   input  logic               in_round,
   input  logic               in_sticky,
   input  logic               in_underflow_a,
   input  logic               in_nx_mul,
   input  logic               in_a_eq_b,
   input  logic [2:0]         in_frm,
   input  logic [2:0]         csr_frm,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [man:0]       out_mantissa,
   output logic [exp:0]       out_exponent,
   output logic               out_sign,
   output logic [4:0]         out_flags,
   output logic               out_rm_illegal,
   output logic [TAG_W-1:0]   out_tag,
   input  logic               flags_clr,
   output logic [4:0]         acc_flags
);

   // std only documents the IEEE word width; folding it in keeps the generic referenced.
   localparam int EXP_W = exp + 1 + (std - std);

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   // ---------------------------------------------------------------- S1 logic
   logic [2:0]       w_rm_res;
   logic             w_rm_illegal;
   logic [2:0]       w_rm_eff;
   logic             w_inx;
   logic             w_up;
   logic [man+2:0]   w_sum;
   logic             w_carry;
   logic [man+1:0]   w_sh;
   logic [exp+1:0]   w_ei;
   logic             w_s1_load;
   logic             w_s2_ready;

   // resolve the dynamic mode; reserved encodings fall back to truncation
   always_comb begin
      w_rm_res     = (in_frm == RM_DYN) ? csr_frm : in_frm;
      w_rm_illegal = (w_rm_res > RM_RMM);
      w_rm_eff     = w_rm_illegal ? RM_RTZ : w_rm_res;
   end

   // round-up decision from the effective mode, sign and G/R/S
   always_comb begin
      w_inx = in_guard | in_round | in_sticky;
      w_up  = 1'b0;
      case (w_rm_eff)
         RM_RNE:  w_up = in_guard & (in_round | in_sticky | in_mantissa[0]);
         RM_RTZ:  w_up = 1'b0;
         RM_RDN:  w_up = w_inx & in_sign;
         RM_RUP:  w_up = w_inx & ~in_sign;
         RM_RMM:  w_up = in_guard;
         default: w_up = 1'b0;
      endcase
   end

   // increment, renormalise on carry-out and bump the exponent
   always_comb begin
      w_sum   = {1'b0, in_mantissa} + {{(man+2){1'b0}}, w_up};
      w_carry = w_sum[man+2];
      w_sh    = w_carry ? w_sum[man+2:1] : w_sum[man+1:0];
      w_ei    = in_exponent + {{EXP_W{1'b0}}, w_carry};
   end

   logic             r1_valid;
   logic [2:0]       r1_rm;
   logic             r1_illegal;
   logic [man+1:0]   r1_sh;
   logic             r1_carry;
   logic [exp+1:0]   r1_ei;
   logic             r1_sign;
   logic             r1_inx;
   logic             r1_underflow_a;
   logic             r1_nx_mul;
   logic             r1_a_eq_b;
   logic [TAG_W-1:0] r1_tag;

   assign w_s2_ready = ~out_valid | out_ready;
   assign in_ready   = ~r1_valid | w_s2_ready;
   assign w_s1_load  = in_valid & in_ready;

   // S1 register: captures an accepted operation, holds while S1 is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid       <= 1'b0;
         r1_rm          <= 3'b000;
         r1_illegal     <= 1'b0;
         r1_sh          <= '0;
         r1_carry       <= 1'b0;
         r1_ei          <= '0;
         r1_sign        <= 1'b0;
         r1_inx         <= 1'b0;
         r1_underflow_a <= 1'b0;
         r1_nx_mul      <= 1'b0;
         r1_a_eq_b      <= 1'b0;
         r1_tag         <= '0;
      end else begin
         if (in_ready) begin
            r1_valid <= in_valid;
         end
         if (w_s1_load) begin
            r1_rm          <= w_rm_eff;
            r1_illegal     <= w_rm_illegal;
            r1_sh          <= w_sh;
            r1_carry       <= w_carry;
            r1_ei          <= w_ei;
            r1_sign        <= in_sign;
            r1_inx         <= w_inx;
            r1_underflow_a <= in_underflow_a;
            r1_nx_mul      <= in_nx_mul;
            r1_a_eq_b      <= in_a_eq_b;
            r1_tag         <= in_tag;
         end
      end
   end

   // ---------------------------------------------------------------- S2 logic
   logic             w_ovf;
   logic             w_to_inf;
   logic             w_tiny;
   logic [exp:0]     w_exp_res;
   logic [man:0]     w_man_res;
   logic             w_sign_res;
   logic [4:0]       w_flags;

   // overflow covers both the pre-overflow bit and an all-ones exponent
   always_comb begin
      w_ovf    = r1_ei[exp+1] | (&r1_ei[exp:0]);
      w_to_inf = (r1_rm == RM_RNE) | (r1_rm == RM_RMM) |
                 ((r1_rm == RM_RUP) & ~r1_sign) | ((r1_rm == RM_RDN) & r1_sign);
      w_tiny   = ~r1_sh[man+1];
   end

   // result fields: saturate on overflow, and flush only the exponent when tiny
   always_comb begin
      w_exp_res = r1_ei[exp:0];
      w_man_res = r1_sh[man:0];
      if (w_ovf) begin
         if (w_to_inf) begin
            w_exp_res = '1;
            w_man_res = '0;
         end else begin
            w_exp_res = {{exp{1'b1}}, 1'b0};
            w_man_res = '1;
         end
      end
      if (w_tiny) begin
         w_exp_res = '0;
      end
   end

   // exact cancellation takes its sign from the rounding mode; flags are {NV,DZ,OF,UF,NX}
   always_comb begin
      w_sign_res = r1_a_eq_b ? (r1_rm == RM_RDN) : r1_sign;
      w_flags    = {1'b0, 1'b0, w_ovf,
                    w_tiny & (r1_inx | r1_underflow_a | r1_nx_mul),
                    r1_inx | w_ovf | r1_underflow_a | r1_nx_mul};
   end

   // S2 register: the visible outputs, frozen while downstream withholds ready
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_mantissa   <= '0;
         out_exponent   <= '0;
         out_sign       <= 1'b0;
         out_flags      <= 5'b00000;
         out_rm_illegal <= 1'b0;
         out_tag        <= '0;
      end else if (w_s2_ready) begin
         out_valid <= r1_valid;
         if (r1_valid) begin
            out_mantissa   <= w_man_res;
            out_exponent   <= w_exp_res;
            out_sign       <= w_sign_res;
            out_flags      <= w_flags;
            out_rm_illegal <= r1_illegal;
            out_tag        <= r1_tag;
         end
      end
   end

   logic w_xfer;
   assign w_xfer = out_valid & out_ready;

   // sticky flag accumulator; a clear that coincides with a transfer keeps that transfer's flags
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_flags <= 5'b00000;
      end else if (flags_clr) begin
         acc_flags <= w_xfer ? out_flags : 5'b00000;
      end else if (w_xfer) begin
         acc_flags <= acc_flags | out_flags;
      end
   end

   // r1_carry is kept with the operation for debug visibility of the renormalise step
   logic w_unused;
   assign w_unused = r1_carry;

endmodule

// File: tb/tb_fmadd_round_pipe.sv
// Directed bench for fmadd_round_pipe (single precision widths) with a result scoreboard.
`timescale 1ns/1ps
module tb_fmadd_round_pipe;
   localparam int MAN = 22;
   localparam int EXP = 7;
   localparam int TW  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready;
   logic [MAN+1:0]  in_mantissa;
   logic [EXP+1:0]  in_exponent;
   logic            in_sign, in_guard, in_round, in_sticky;
   logic            in_underflow_a, in_nx_mul, in_a_eq_b;
   logic [2:0]      in_frm, csr_frm;
   logic [TW-1:0]   in_tag;
   logic            out_valid, out_ready;
   logic [MAN:0]    out_mantissa;
   logic [EXP:0]    out_exponent;
   logic            out_sign;
   logic [4:0]      out_flags;
   logic            out_rm_illegal;
   logic [TW-1:0]   out_tag;
   logic            flags_clr;
   logic [4:0]      acc_flags;

   fmadd_round_pipe #(.std(31), .man(MAN), .exp(EXP), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mantissa(in_mantissa), .in_exponent(in_exponent),
      .in_sign(in_sign), .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
      .in_underflow_a(in_underflow_a), .in_nx_mul(in_nx_mul), .in_a_eq_b(in_a_eq_b),
      .in_frm(in_frm), .csr_frm(csr_frm), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mantissa(out_mantissa), .out_exponent(out_exponent), .out_sign(out_sign),
      .out_flags(out_flags), .out_rm_illegal(out_rm_illegal), .out_tag(out_tag),
      .flags_clr(flags_clr), .acc_flags(acc_flags)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [22:0] m;
      logic [7:0]  e;
      logic        s;
      logic [4:0]  f;
      logic        ill;
      logic [3:0]  tag;
   } res_t;

   typedef struct packed {
      logic [23:0] m;
      logic [8:0]  e;
      logic        s, g, r, st, uf, nxm, aeb;
      logic [2:0]  frm, csr;
      logic [22:0] xm;
      logic [7:0]  xe;
      logic        xs;
      logic [4:0]  xf;
      logic        xill;
   } vec_t;

   res_t       sbq[$];
   int         total = 0;
   int         bad   = 0;
   logic [4:0] acc_model;
   logic       held_v;
   res_t       held;

   function automatic vec_t mkv(logic [23:0] m, logic [8:0] e, logic s, logic g, logic r,
                                logic st, logic uf, logic nxm, logic aeb, logic [2:0] frm,
                                logic [2:0] csr, logic [22:0] xm, logic [7:0] xe, logic xs,
                                logic [4:0] xf, logic xill);
      vec_t v;
      v.m = m; v.e = e; v.s = s; v.g = g; v.r = r; v.st = st; v.uf = uf; v.nxm = nxm;
      v.aeb = aeb; v.frm = frm; v.csr = csr;
      v.xm = xm; v.xe = xe; v.xs = xs; v.xf = xf; v.xill = xill;
      return v;
   endfunction

   function automatic res_t exp_of(vec_t v, logic [3:0] tag);
      res_t r;
      r.m = v.xm; r.e = v.xe; r.s = v.xs; r.f = v.xf; r.ill = v.xill; r.tag = tag;
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic drive(vec_t v, logic [3:0] tag);
      in_mantissa = v.m; in_exponent = v.e; in_sign = v.s;
      in_guard = v.g; in_round = v.r; in_sticky = v.st;
      in_underflow_a = v.uf; in_nx_mul = v.nxm; in_a_eq_b = v.aeb;
      in_frm = v.frm; csr_frm = v.csr; in_tag = tag;
   endtask

   // called once per cycle at the falling edge: acc, stall stability, scoreboard pop
   task automatic mon();
      res_t o;
      res_t e;
      o = {out_mantissa, out_exponent, out_sign, out_flags, out_rm_illegal, out_tag};
      chk("acc_flags", 64'(acc_flags), 64'(acc_model));
      if (held_v) chk("stall_hold", 64'(o), 64'(held));
      held_v = out_valid & ~out_ready;
      held   = o;
      if (out_valid && out_ready) begin
         chk("out_expected", 64'(sbq.size() != 0), 64'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk($sformatf("result_tag%0d", e.tag), 64'(o), 64'(e));
            acc_model = flags_clr ? e.f : (acc_model | e.f);
         end
      end else if (flags_clr) begin
         acc_model = 5'b00000;
      end
   endtask

   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic send(vec_t v, logic [3:0] tag);
      logic ok;
      ok = 1'b0;
      drive(v, tag);
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         mon();
         if (in_ready) begin
            ok = 1'b1;
            sbq.push_back(exp_of(v, tag));
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("accept", 64'(ok), 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
      chk("drain", 64'(sbq.size()), 64'd0);
   endtask

   vec_t dv[10];
   vec_t sv[6];

   initial begin
      // directed cases: M, E, sign, G, R, S, uf, nx_mul, a_eq_b, frm, csr -> mant, exp, sign, flags, illegal
      dv[0] = mkv(24'hFFFFFF, 9'h07E, 0, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 23'h000000, 8'h7F, 0, 5'b00001, 0);
      dv[1] = mkv(24'hFFFFFF, 9'h0FE, 0, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 23'h000000, 8'hFF, 0, 5'b00101, 0);
      dv[2] = mkv(24'hFFFFFF, 9'h0FF, 0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 23'h7FFFFF, 8'hFE, 0, 5'b00101, 0);
      dv[3] = mkv(24'h400000, 9'h000, 0, 1, 0, 1, 0, 0, 0, 3'b011, 3'b000, 23'h400001, 8'h00, 0, 5'b00011, 0);
      dv[4] = mkv(24'h400000, 9'h000, 0, 1, 0, 1, 0, 0, 0, 3'b001, 3'b000, 23'h400000, 8'h00, 0, 5'b00011, 0);
      dv[5] = mkv(24'h000000, 9'h000, 0, 0, 0, 0, 0, 0, 1, 3'b111, 3'b010, 23'h000000, 8'h00, 1, 5'b00000, 0);
      dv[6] = mkv(24'h800001, 9'h010, 0, 1, 0, 0, 0, 0, 0, 3'b101, 3'b000, 23'h000001, 8'h10, 0, 5'b00001, 1);
      dv[7] = mkv(24'hFFFFFF, 9'h0FF, 1, 0, 0, 0, 0, 0, 0, 3'b011, 3'b000, 23'h7FFFFF, 8'hFE, 1, 5'b00101, 0);
      dv[8] = mkv(24'hFFFFFF, 9'h0FF, 1, 0, 0, 0, 0, 0, 0, 3'b010, 3'b000, 23'h000000, 8'hFF, 1, 5'b00101, 0);
      dv[9] = mkv(24'h400000, 9'h000, 0, 0, 0, 0, 1, 0, 0, 3'b000, 3'b000, 23'h400000, 8'h00, 0, 5'b00011, 0);
      // stream: flags OR over tags 0..4 is 00111; tag 5 alone is 00001
      sv[0] = dv[0];
      sv[1] = mkv(24'h800001, 9'h080, 0, 0, 0, 0, 0, 1, 0, 3'b000, 3'b000, 23'h000001, 8'h80, 0, 5'b00001, 0);
      sv[2] = dv[3];
      sv[3] = dv[1];
      sv[4] = mkv(24'hC00000, 9'h010, 1, 0, 1, 0, 0, 0, 0, 3'b010, 3'b000, 23'h400001, 8'h10, 1, 5'b00001, 0);
      sv[5] = mkv(24'hABCDEF, 9'h042, 0, 1, 0, 0, 0, 0, 0, 3'b111, 3'b100, 23'h2BCDF0, 8'h42, 0, 5'b00001, 0);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
      drive(dv[0], 4'd0);
      acc_model = 5'b00000; held_v = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_outputs", 64'({out_mantissa, out_exponent, out_sign, out_flags, out_rm_illegal, out_tag}), 64'd0);
      chk("rst_acc", 64'(acc_flags), 64'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         send(dv[i], 4'(i + 6));
         drain();
      end

      // back-to-back stream with a downstream stall and a coincident flags clear
      acc_model = acc_flags;
      begin
         int   idx;
         logic saw_block;
         idx = 0;
         saw_block = 1'b0;
         flags_clr = 1'b1;
         step();
         flags_clr = 1'b0;
         for (int cyc = 0; cyc < 60 && (idx < 6 || sbq.size() != 0); cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (idx < 6) begin
               drive(sv[idx], 4'(idx));
               in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && out_ready && out_tag == 4'd5) flags_clr = 1'b1;
            if (out_valid && out_ready && out_tag == 4'd5)
               chk("acc_before_clr", 64'(acc_flags), 64'(5'b00111));
            mon();
            if (in_valid && in_ready) begin
               sbq.push_back(exp_of(sv[idx], 4'(idx)));
               idx++;
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            @(posedge clk);
            #1;
            flags_clr = 1'b0;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         chk("in_ready_fell", 64'(saw_block), 64'd1);
         chk("stream_sent", 64'(idx), 64'd6);
         chk("stream_drained", 64'(sbq.size()), 64'd0);
         @(negedge clk);
         chk("acc_after_clr", 64'(acc_flags), 64'(5'b00001));
         mon();
         @(posedge clk);
         #1;
      end

      // reset with two operations in flight
      send(sv[1], 4'd1);
      send(sv[2], 4'd2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sbq.delete();
      acc_model = 5'b00000;
      held_v = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_acc", 64'(acc_flags), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      send(sv[3], 4'd9);
      @(negedge clk);
      chk("lat_s1", 64'(out_valid), 64'd0);
      mon();
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("lat_s2", 64'(out_valid), 64'd1);
      mon();
      @(posedge clk);
      #1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
